pipe_mux_arb: RTL and testbench
===============================

PIPE_MUX_ARB -- requirements
Module: pipe_mux_arb

Interface
REQ-001 Parameter N_CH, default 8: number of input channels, 2..16.
REQ-002 Parameter WIDTH, default 1: data bits per channel, 1..32.
REQ-003 Parameter SEL_W, default 3: width of sel and out_ch, equal to ceil(log2(N_CH)).
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 Port mode  in  1  arbitration mode: 0 = fixed select from sel, 1 = round-robin.
REQ-007 Port sel  in  SEL_W  channel index used when mode = 0.
REQ-008 Port in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port in_valid  in  N_CH  per-channel valid.
REQ-010 Port in_ready  out  N_CH  per-channel ready; combinational.
REQ-011 Port out_data  out  WIDTH  registered selected data.
REQ-012 Port out_ch  out  SEL_W  registered index of the channel that sourced out_data.
REQ-013 Port out_valid  out  1  registered output valid.
REQ-014 Port out_ready  in  1  downstream ready.

Function
REQ-015 A transfer on channel i occurs when in_valid[i] and in_ready[i] are both 1 at a clock edge; an output transfer occurs when out_valid and out_ready are both 1.
REQ-016 load = !out_valid || out_ready; at most one in_ready bit is 1, and only while load = 1.
REQ-017 mode = 0: grant channel sel if sel < N_CH and in_valid[sel] = 1; no grant if sel >= N_CH.
REQ-018 mode = 1: grant the first channel with in_valid = 1, searching upward from ptr+1 modulo N_CH, where ptr is the last granted channel.
REQ-019 On a granted transfer: out_data <= granted data, out_ch <= granted index, out_valid <= 1, and in mode 1, ptr <= granted index. Latency from input transfer to out_valid is 1 cycle.
REQ-020 load = 1 with no grant: out_valid <= 0, and out_data, out_ch and ptr hold.
REQ-021 load = 0 (stall): out_data, out_ch, out_valid and ptr hold, and every in_ready = 0.
REQ-022 Full throughput: with out_ready held at 1, one transfer per cycle.
REQ-023 A mode or sel change takes effect on the same cycle's grant; ptr is not modified in mode 0.
REQ-024 Round-robin wrap: after a grant to channel N_CH-1, the search starts at channel 0.

Reset
REQ-025 rst_n = 0 immediately forces out_valid = 0, out_data = 0, out_ch = 0, ptr = N_CH-1 (channel 0 has first priority) and all in_ready = 0, regardless of clk.
REQ-026 Reset asserted while a word is held discards that word; the first cycle after release behaves as an empty output stage.

Configuration
REQ-027 Macro PIPE_MUX_ARB_STATS_EN: when defined, add output port xfer_cnt (16 bits) counting output transfers, reset to 0 and saturating at 16'hFFFF.
REQ-028 When PIPE_MUX_ARB_STATS_EN is undefined, xfer_cnt and its counter are absent and all other behaviour is identical.

Verification
REQ-029 Reset: rst_n = 0 mid-stream with out_valid = 1 -> out_valid, out_data and out_ch are 0 at once; after release with in_valid = 8'h01, the grant goes to channel 0.
REQ-030 Fixed mode: N_CH = 8, WIDTH = 4, mode = 0, sel = 5, in_valid = 8'hFF, channel 5 data = 4'hA -> the next cycle has out_valid = 1, out_data = 4'hA, out_ch = 5; sel = 9 style out-of-range (N_CH = 6, sel = 7) -> no in_ready, and out_valid drops.
REQ-031 Round-robin: mode = 1, in_valid = 8'hFF, out_ready = 1 -> out_ch sequence 0,1,...,7,0 on consecutive cycles.
REQ-032 Sparse round-robin: in_valid = 8'b1000_0100, ptr = 2 -> grants 7, then 2, then 7.
REQ-033 Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> out_data and out_ch are stable and in_ready = 0 throughout; out_ready = 1 -> the next word loads on the same edge.
REQ-034 Stats (macro defined): 70000 output transfers -> xfer_cnt = 16'hFFFF; stalled cycles do not increment it.

Source files
------------

// File: rtl/pipe_mux_arb.sv
// pipe_mux_arb: N_CH-to-1 multiplexer/arbiter with one registered output stage.
// mode 0 picks the channel named by sel; mode 1 round-robins over valid channels.
// Optional transfer counter enabled by defining PIPE_MUX_ARB_STATS_EN.
module pipe_mux_arb #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned SEL_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
`ifdef PIPE_MUX_ARB_STATS_EN
  output logic [15:0]             xfer_cnt,
`endif
  input  logic                    out_ready
);

  logic             load;
  logic [SEL_W-1:0] ptr;
  logic [N_CH-1:0]  rr_mask;
  logic [N_CH-1:0]  rr_hi;
  logic             gnt_any;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  // Output stage can accept a new word when empty or draining this cycle.
  assign load = !out_valid || out_ready;

  // Lowest-index set bit of a request vector.
  function automatic logic [SEL_W-1:0] first_set(input logic [N_CH-1:0] v);
    first_set = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (v[i]) first_set = SEL_W'(i);
    end
  endfunction

  // Requests strictly above ptr have priority; otherwise wrap to the lowest request.
  always_comb begin
    rr_mask = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      rr_mask[i] = (i > int'(ptr));
    end
    rr_hi = in_valid & rr_mask;
  end

  // Grant selection for both arbitration modes.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!mode) begin
      if (int'(sel) < int'(N_CH)) begin
        gnt_any = in_valid[sel];
        gnt_idx = sel;
      end
    end else begin
      gnt_any = |in_valid;
      gnt_idx = (|rr_hi) ? first_set(rr_hi) : first_set(in_valid);
    end
  end

  assign gnt_data = in_data[int'(gnt_idx)*int'(WIDTH) +: WIDTH];

  // One-hot ready to the granted channel; forced low during reset and stalls.
  always_comb begin
    in_ready = '0;
    if (rst_n && load && gnt_any) in_ready[gnt_idx] = 1'b1;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SEL_W'(N_CH - 1);
    end else if (load) begin
      if (gnt_any) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt_idx;
        if (mode) ptr <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PIPE_MUX_ARB_STATS_EN
  // Saturating count of completed output transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready && (xfer_cnt != 16'hFFFF)) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mux_arb.sv
// Bench for pipe_mux_arb: an 8-channel and a 6-channel instance share stimulus,
// both compared against a transaction-level reference model.
module tb_pipe_mux_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [2:0]  sel;
  logic [31:0] in_data;
  logic [7:0]  in_valid;
  logic        out_ready;

  logic [7:0]  rdy8;
  logic [3:0]  od8;
  logic [2:0]  oc8;
  logic        ov8;
  logic [5:0]  rdy6;
  logic [3:0]  od6;
  logic [2:0]  oc6;
  logic        ov6;
`ifdef PIPE_MUX_ARB_STATS_EN
  logic [15:0] cnt8;
  logic [15:0] cnt6;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state per instance
  int nch[2] = '{8, 6};
  int m_v[2];
  int m_d[2];
  int m_c[2];
  int m_p[2];
  int m_cnt[2];

  always #5 clk = ~clk;

  pipe_mux_arb #(.N_CH(8), .WIDTH(4), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy8), .out_data(od8), .out_ch(oc8), .out_valid(ov8),
`ifdef PIPE_MUX_ARB_STATS_EN
    .xfer_cnt(cnt8),
`endif
    .out_ready(out_ready)
  );

  pipe_mux_arb #(.N_CH(6), .WIDTH(4), .SEL_W(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data[23:0]),
    .in_valid(in_valid[5:0]), .in_ready(rdy6), .out_data(od6), .out_ch(oc6), .out_valid(ov6),
`ifdef PIPE_MUX_ARB_STATS_EN
    .xfer_cnt(cnt6),
`endif
    .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Which channel the rules award this cycle, or -1.
  function automatic int model_grant(input int n, input int p, input logic md,
                                     input logic [2:0] s, input logic [7:0] v);
    if (!md) return (int'(s) < n && v[s]) ? int'(s) : -1;
    for (int k = 1; k <= n; k++) begin
      if (v[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [7:0] valid_for(input int i);
    return (i == 0) ? in_valid : (in_valid & 8'h3F);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_d[i] = 0; m_c[i] = 0; m_p[i] = nch[i] - 1; m_cnt[i] = 0;
    end
  endtask

  task automatic check_outputs();
    check("ov8", 32'(ov8), 32'(m_v[0]));
    check("od8", 32'(od8), 32'(m_d[0]));
    check("oc8", 32'(oc8), 32'(m_c[0]));
    check("ov6", 32'(ov6), 32'(m_v[1]));
    check("od6", 32'(od6), 32'(m_d[1]));
    check("oc6", 32'(oc6), 32'(m_c[1]));
`ifdef PIPE_MUX_ARB_STATS_EN
    check("cnt8", 32'(cnt8), 32'(m_cnt[0]));
    check("cnt6", 32'(cnt6), 32'(m_cnt[1]));
`endif
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    int g[2];
    int exp_rdy;
    #1;
    for (int i = 0; i < 2; i++) begin
      g[i] = model_grant(nch[i], m_p[i], mode, sel, valid_for(i));
      exp_rdy = ((m_v[i] == 0 || out_ready) && g[i] >= 0) ? (1 << g[i]) : 0;
      check(i == 0 ? "rdy8" : "rdy6", i == 0 ? 32'(rdy8) : 32'(rdy6), 32'(exp_rdy));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (m_v[i] != 0 && out_ready && m_cnt[i] < 65535) m_cnt[i]++;
      if (m_v[i] == 0 || out_ready) begin
        if (g[i] >= 0) begin
          m_v[i] = 1;
          m_d[i] = int'((in_data >> (g[i] * 4)) & 32'hF);
          m_c[i] = g[i];
          if (mode) m_p[i] = g[i];
        end else begin
          m_v[i] = 0;
        end
      end
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    check("rst_ov8", 32'(ov8), 0);
    check("rst_od8", 32'(od8), 0);
    check("rst_oc8", 32'(oc8), 0);
    check("rst_rdy8", 32'(rdy8), 0);
    check("rst_rdy6", 32'(rdy6), 0);
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = 3'd0; in_data = 32'h7654_3210;
    in_valid = 8'hFF; out_ready = 1'b1;
    model_reset();
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed select of channel 5
    mode = 1'b0; sel = 3'd5; in_data = 32'h76A4_3210; in_valid = 8'hFF;
    cycle();
    check("fix_od", 32'(od8), 32'hA);
    check("fix_oc", 32'(oc8), 32'd5);
    check("fix_ov", 32'(ov8), 32'd1);

    // Round-robin with all channels valid, starting from the reset pointer
    mode = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_data = $urandom;
      cycle();
      check("rr_oc", 32'(oc8), 32'(k % 8));
    end

    // Move pointer to 2, then sparse requests alternate 7 and 2
    in_valid = 8'h04;
    cycle();
    check("sp_oc2", 32'(oc8), 32'd2);
    in_valid = 8'h84;
    cycle();
    check("sp_a", 32'(oc8), 32'd7);
    cycle();
    check("sp_b", 32'(oc8), 32'd2);
    cycle();
    check("sp_c", 32'(oc8), 32'd7);

    // Backpressure: held word stays put, no ready, then loads on release
    in_valid = 8'hFF;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      cycle();
      check("bp_oc", 32'(oc8), 32'd7);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_load", 32'(oc8), 32'd0);

    // Out-of-range select on the 6-channel instance
    mode = 1'b0; sel = 3'd7; in_valid = 8'hFF;
    #1;
    check("oor_rdy6", 32'(rdy6), 0);
    cycle();
    check("oor_ov6", 32'(ov6), 0);
    check("oor_oc8", 32'(oc8), 32'd7);

    // Reset mid-stream while a word is held
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1; mode = 1'b1; in_valid = 8'h01;
    cycle();
    check("post_rst_oc", 32'(oc8), 32'd0);
    check("post_rst_ov", 32'(ov8), 32'd1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      mode      = 1'($urandom);
      sel       = 3'($urandom);
      in_data   = $urandom;
      in_valid  = 8'($urandom) & 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

`ifdef PIPE_MUX_ARB_STATS_EN
    // Drive past saturation without per-cycle checks
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 70000; k++) @(posedge clk);
    #1;
    check("cnt_sat8", 32'(cnt8), 32'hFFFF);
    check("cnt_sat6", 32'(cnt6), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
